// File: rtl/spi_cmd_pkg.sv
// Shared constants, FSM state type and draw-command layout for the SPI
// draw-command receiver.
package spi_cmd_pkg;

   localparam int unsigned H_ACTIVE = 640;
   localparam int unsigned V_ACTIVE = 480;
   localparam int unsigned CMD_BITS = 24;
   localparam int unsigned CNT_W    = 5;
   localparam int unsigned ECHO_W   = 8;
   localparam int unsigned X_W      = 10;
   localparam int unsigned Y_W      = 10;
   localparam int unsigned COLOR_W  = 3;

   localparam logic [ECHO_W-1:0] ECHO_INIT = 8'hA5;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } rx_state_e;

   // Bit order matches the wire format: brush is the first bit received.
   typedef struct packed {
      logic               brush;
      logic [COLOR_W-1:0] color;
      logic [X_W-1:0]     x;
      logic [Y_W-1:0]     y;
   } draw_cmd_t;

   function automatic logic cmd_in_range(input draw_cmd_t c);
      return (32'(c.x) < H_ACTIVE) && (32'(c.y) < V_ACTIVE);
   endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser for an asynchronous level, plus single-cycle
// rise/fall pulses derived from the synchronised value.
module sync_edge #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic i_async,
   output logic o_sync,
   output logic o_rise_c,
   output logic o_fall_c
);

   logic r_meta;
   logic r_sync;
   logic r_prev;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_meta <= RST_VAL;
         r_sync <= RST_VAL;
         r_prev <= RST_VAL;
      end else begin
         r_meta <= i_async;
         r_sync <= r_meta;
         r_prev <= r_sync;
      end
   end

   assign o_sync   = r_sync;
   assign o_rise_c = r_sync & ~r_prev;
   assign o_fall_c = ~r_sync & r_prev;

endmodule

// File: rtl/spi_cmd_rx.sv
// SPI mode-0 slave that assembles 24-bit draw commands, range-checks them and
// echoes the received byte stream (A5 lead-in) back on sdo.
module spi_cmd_rx
   import spi_cmd_pkg::*;
#(
   parameter int unsigned SCK_DIV_MIN = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               sck,
   input  logic               sdi,
   input  logic               cs_n,
   output logic               sdo,
   output logic               cmd_valid,
   output logic [X_W-1:0]     cmd_x,
   output logic [Y_W-1:0]     cmd_y,
   output logic [COLOR_W-1:0] cmd_color,
   output logic               cmd_brush,
   output logic               frame_err
);

   logic w_sck_sync, w_sck_rise_c, w_sck_fall_c;
   logic w_cs_sync, w_cs_rise_c, w_cs_fall_c;

   sync_edge #(.RST_VAL(1'b0)) u_sck_sync (
      .clk      (clk),
      .reset    (reset),
      .i_async  (sck),
      .o_sync   (w_sck_sync),
      .o_rise_c (w_sck_rise_c),
      .o_fall_c (w_sck_fall_c)
   );

   sync_edge #(.RST_VAL(1'b1)) u_cs_sync (
      .clk      (clk),
      .reset    (reset),
      .i_async  (cs_n),
      .o_sync   (w_cs_sync),
      .o_rise_c (w_cs_rise_c),
      .o_fall_c (w_cs_fall_c)
   );

   // sdi gets the same two-flop latency as sck so it lines up with the rise pulse.
   logic r_sdi_meta, r_sdi_sync;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_sdi_meta <= 1'b0;
         r_sdi_sync <= 1'b0;
      end else begin
         r_sdi_meta <= sdi;
         r_sdi_sync <= r_sdi_meta;
      end
   end

   rx_state_e              r_state, w_state_nxt;
   logic [CNT_W-1:0]       r_bit_cnt;
   logic [CMD_BITS-1:0]    r_shift;
   logic [ECHO_W-1:0]      r_echo;
   draw_cmd_t              r_cmd;
   logic                   r_valid;
   logic                   r_err;

   logic                   w_enter_c, w_exit_c, w_abort_c;
   logic                   w_shift_en_c, w_word_done_c, w_echo_en_c;
   logic [CMD_BITS-1:0]    w_shift_nxt;
   draw_cmd_t              w_cmd;

   assign w_shift_nxt = {r_shift[CMD_BITS-2:0], r_sdi_sync};
   assign w_cmd       = draw_cmd_t'(w_shift_nxt);

   always_ff @(posedge clk) begin
      if (!reset) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   // Frame control: sck edges only matter while the frame is open.
   always_comb begin
      w_state_nxt   = r_state;
      w_enter_c     = 1'b0;
      w_exit_c      = 1'b0;
      w_abort_c     = 1'b0;
      w_shift_en_c  = 1'b0;
      w_word_done_c = 1'b0;
      w_echo_en_c   = 1'b0;
      case (r_state)
         IDLE: begin
            if (!w_cs_sync) begin
               w_state_nxt = SHIFT;
               w_enter_c   = 1'b1;
            end
         end
         SHIFT: begin
            if (w_cs_sync) begin
               w_state_nxt = IDLE;
               w_exit_c    = 1'b1;
               w_abort_c   = (r_bit_cnt != '0);
            end else begin
               w_shift_en_c  = w_sck_rise_c;
               w_word_done_c = w_sck_rise_c && (r_bit_cnt == CNT_W'(CMD_BITS - 1));
               w_echo_en_c   = w_sck_fall_c;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_bit_cnt <= '0;
         r_shift   <= '0;
         r_echo    <= '0;
         r_cmd     <= '0;
         r_valid   <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         if (w_shift_en_c) begin
            r_shift   <= w_shift_nxt;
            r_bit_cnt <= w_word_done_c ? '0 : r_bit_cnt + CNT_W'(1);
         end
         if (w_exit_c)  r_bit_cnt <= '0;
         if (w_abort_c) r_err     <= 1'b1;
         if (w_word_done_c) begin
            if (cmd_in_range(w_cmd)) begin
               r_cmd   <= w_cmd;
               r_valid <= 1'b1;
            end else begin
               r_err   <= 1'b1;
            end
         end
         // A fall with the count on a byte boundary follows a completed byte.
         if (w_enter_c)
            r_echo <= ECHO_INIT;
         else if (w_exit_c)
            r_echo <= '0;
         else if (w_echo_en_c)
            r_echo <= (r_bit_cnt[2:0] == 3'd0) ? r_shift[ECHO_W-1:0]
                                               : {r_echo[ECHO_W-2:0], 1'b0};
      end
   end

   logic w_div_ok_c;
   logic w_unused_c;
   assign w_div_ok_c = (SCK_DIV_MIN >= 32'd4);
   assign w_unused_c = ^{w_sck_sync, w_cs_rise_c, w_cs_fall_c,
                         r_shift[CMD_BITS-1], w_div_ok_c};

   assign sdo       = r_echo[ECHO_W-1];
   assign cmd_valid = r_valid;
   assign cmd_x     = r_cmd.x;
   assign cmd_y     = r_cmd.y;
   assign cmd_color = r_cmd.color;
   assign cmd_brush = r_cmd.brush;
   assign frame_err = r_err;

endmodule

// File: doc/spi_cmd_rx.md
SPI_CMD_RX -- requirements
Module: spi_cmd_rx

Interface
REQ-001 Parameter SCK_DIV_MIN, default 8, minimum clk cycles per sck period the block is guaranteed to track.
REQ-002 clk  input  1  system/VGA pixel clock; all state on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset.
REQ-004 sck  input  1  SPI clock from MCU, asynchronous to clk, mode 0.
REQ-005 sdi  input  1  SPI data MCU->FPGA, MSB first.
REQ-006 cs_n  input  1  SPI chip select, active-low, asynchronous.
REQ-007 sdo  output  1  SPI data FPGA->MCU, echo stream.
REQ-008 cmd_valid  output  1  one-clk pulse, new draw command on cmd_* outputs.
REQ-009 cmd_x  output  10  pixel column, 0..639.
REQ-010 cmd_y  output  10  pixel row, 0..479.
REQ-011 cmd_color  output  3  colour code.
REQ-012 cmd_brush  output  1  1 = paint, 0 = erase.
REQ-013 frame_err  output  1  sticky flag: out-of-range command or truncated frame seen.

Function
REQ-014 sck, cs_n, sdi: two-flop synchronised in clk domain; sck rise/fall derived as single-cycle pulses from synchronised sck.
REQ-015 FSM states IDLE, SHIFT; IDLE->SHIFT on synchronised cs_n low; SHIFT->IDLE on synchronised cs_n high.
REQ-016 In SHIFT, each sck rise pulse shifts synchronised sdi into 24-bit shift register LSB end; 5-bit bit counter increments.
REQ-017 Command word bits [23:0]: [23] brush, [22:20] color, [19:10] x, [9:0] y.
REQ-018 On sck rise pulse completing bit 24: bit counter wraps to 0; command checked; cmd_valid asserted exactly one clk later.
REQ-019 Range check: x >= 640 or y >= 480 -> cmd_valid not asserted, cmd_* unchanged, frame_err set.
REQ-020 cmd_* hold last accepted command until the next accepted command.
REQ-021 Streaming: further bytes under same cs_n low start a new 24-bit command; no gap required.
REQ-022 cs_n rising with bit counter != 0: partial command discarded, frame_err set, counter cleared.
REQ-023 cs_n rising with bit counter == 0: no error; counter stays 0.
REQ-024 frame_err cleared only by reset.
REQ-025 sdo: 8-bit echo register shifted out MSB first, updated on sck fall pulse; first byte of every frame = 8'hA5, each later byte = previous received byte.
REQ-026 sdo drives 0 in IDLE.
REQ-027 sck edges while cs_n high ignored; counters unchanged.
REQ-028 cs_n falling and sck rise in same clk: FSM enters SHIFT, that sck rise ignored.

Reset
REQ-029 reset low at clk edge: FSM IDLE, counters 0, shift/echo registers 0, synchronisers 1 for cs_n and 0 for sck/sdi.
REQ-030 Reset values: cmd_valid 0, cmd_x 0, cmd_y 0, cmd_color 0, cmd_brush 0, frame_err 0, sdo 0.
REQ-031 Reset mid-frame discards partial command; no cmd_valid pulse; first frame after reset starts at bit 0.

Structure
REQ-032 Package spi_cmd_pkg holds H_ACTIVE=640, V_ACTIVE=480, CMD_BITS=24, ECHO_INIT=8'hA5, FSM state enum, draw-command struct typedef.
REQ-033 One sub-module sync_edge (two-flop synchroniser + rise/fall pulse), instanced for sck and cs_n.

Verification
REQ-034 cs_n low, send 0xD0 0x50 0x64 (brush 1, color 5, x 20, y 100), cs_n high -> one cmd_valid pulse, cmd_x 20, cmd_y 100, cmd_color 5, cmd_brush 1, frame_err 0.
REQ-035 One frame of 6 bytes, two valid commands -> two cmd_valid pulses, second command values on outputs; sdo returns A5 then bytes 1-5.
REQ-036 Command x=640, y=0 -> no cmd_valid, frame_err 1, cmd_* keep prior values.
REQ-037 cs_n high after 13 bits -> no cmd_valid, frame_err 1; next full frame accepted normally.
REQ-038 reset low after 16 bits, then full valid frame -> all outputs at reset values during reset, exactly one cmd_valid afterwards with correct fields.
REQ-039 sck at clk/8, 12 toggles with cs_n high -> no cmd_valid, sdo 0, frame_err 0.
